// File: rtl/aes_seq_pkg.sv
// Shared types and word geometry for the AES core sequencer.
package aes_seq_pkg;
  localparam int WORDS  = 4;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    START,
    LOAD,
    WAIT,
    CAPT,
    DONE
  } seq_state_e;
endpackage

// File: rtl/aes_word_shreg.sv
// Four-word shift register: parallel load, shift towards the top word with serial fill at the bottom.
module aes_word_shreg
  import aes_seq_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      shift,
  input  logic [WORDS*WORD_W-1:0]   load_data,
  input  logic [WORD_W-1:0]         ser_in,
  output logic [WORDS*WORD_W-1:0]   data
);
  logic [WORDS*WORD_W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_data;
    end else if (shift) begin
      data_d = {data_q[(WORDS-1)*WORD_W-1:0], ser_in};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;
endmodule

// File: rtl/aes_core_seq.sv
// Sequencer in front of the word-serial AES core: warm-up, block accept, word-timed load,
// latency wait, result gathering and valid/ready hand-off of the 128-bit result.
//   INIT  | core warm-up after reset, core_start held high
//   IDLE  | ready for a block
//   START | core_start pulse before the first word
//   LOAD  | four text words driven to the core
//   WAIT  | core latency
//   CAPT  | four result words sampled from the core
//   DONE  | result offered downstream
module aes_core_seq
  import aes_seq_pkg::*;
#(
  parameter int INIT_CYCLES  = 88,
  parameter int START_CYCLES = 2,
  parameter int CORE_LATENCY = 79
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_text,
  input  logic [127:0] in_key,
  input  logic         in_dec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_text,
  output logic         busy,
  output logic         core_start,
  output logic [31:0]  core_data_in,
  output logic [127:0] core_key_in,
  output logic         core_selEncDec,
  input  logic [31:0]  core_data_out
);
  localparam int MAX_CNT = (INIT_CYCLES > CORE_LATENCY) ? INIT_CYCLES : CORE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               core_start_q, core_start_d;
  logic [WORD_W-1:0]  core_data_in_q, core_data_in_d;
  logic [127:0]       core_key_in_q, core_key_in_d;
  logic               core_sel_q, core_sel_d;

  logic               ld_load, ld_shift, cap_shift;
  logic [WORD_W-1:0]  ld_head;
  logic [(WORDS-1)*WORD_W-1:0] ld_tail_unused;

  aes_word_shreg u_load_shreg (
    .clk       (clk),
    .reset     (reset),
    .load      (ld_load),
    .shift     (ld_shift),
    .load_data (in_text),
    .ser_in    ('0),
    .data      ({ld_head, ld_tail_unused})
  );

  aes_word_shreg u_capt_shreg (
    .clk       (clk),
    .reset     (reset),
    .load      (1'b0),
    .shift     (cap_shift),
    .load_data ('0),
    .ser_in    (core_data_out),
    .data      (out_text)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    in_ready_d     = 1'b0;
    out_valid_d    = 1'b0;
    core_start_d   = core_start_q;
    core_data_in_d = '0;
    core_key_in_d  = core_key_in_q;
    core_sel_d     = core_sel_q;
    ld_load        = 1'b0;
    ld_shift       = 1'b0;
    cap_shift      = 1'b0;

    case (state_q)
      INIT: begin
        if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
          state_d      = IDLE;
          cnt_d        = '0;
          core_start_d = 1'b0;
          in_ready_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          state_d       = START;
          in_ready_d    = 1'b0;
          ld_load       = 1'b1;
          core_key_in_d = in_key;
          core_sel_d    = in_dec;
          core_start_d  = 1'b1;
          cnt_d         = CNT_W'(START_CYCLES - 1);
        end
      end
      START: begin
        if (cnt_q == '0) begin
          state_d        = LOAD;
          core_start_d   = 1'b0;
          cnt_d          = CNT_W'(WORDS - 1);
          core_data_in_d = ld_head;
          ld_shift       = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LOAD: begin
        if (cnt_q == '0) begin
          // word 3 is on the bus this cycle; output word 0 arrives CORE_LATENCY cycles from now
          state_d = WAIT;
          cnt_d   = CNT_W'(CORE_LATENCY - 2);
        end else begin
          cnt_d          = cnt_q - 1'b1;
          core_data_in_d = ld_head;
          ld_shift       = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = CAPT;
          cnt_d   = CNT_W'(WORDS - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CAPT: begin
        cap_shift = 1'b1;
        if (cnt_q == '0) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d    = IDLE;
          in_ready_d = 1'b1;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= INIT;
      cnt_q          <= '0;
      in_ready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      busy_q         <= 1'b1;
      core_start_q   <= 1'b1;
      core_data_in_q <= '0;
      core_key_in_q  <= '0;
      core_sel_q     <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      busy_q         <= busy_d;
      core_start_q   <= core_start_d;
      core_data_in_q <= core_data_in_d;
      core_key_in_q  <= core_key_in_d;
      core_sel_q     <= core_sel_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign busy           = busy_q;
  assign core_start     = core_start_q;
  assign core_data_in   = core_data_in_q;
  assign core_key_in    = core_key_in_q;
  assign core_selEncDec = core_sel_q;
endmodule

// File: tb/tb_aes_core_seq.sv
// Bench for aes_core_seq: behavioural word-serial AES core model, scoreboard of expected results
// and a monitor that checks every retired block plus its accept-to-valid latency.
module tb_aes_core_seq;
  localparam int INIT_CYC = 88;
  localparam int LAT      = 2 + 4 + (79 - 1) + 4;   // accept edge to out_valid
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_dec, out_valid, out_ready, busy;
  logic [127:0] in_text, in_key, out_text, core_key_in;
  logic         core_start, core_selEncDec;
  logic [31:0]  core_data_in, core_data_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  int n_done  = 0;
  logic [127:0] sb_q[$];

  logic [7:0] sbox  [256];
  logic [7:0] isbox [256];

  aes_core_seq dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_text        (in_text),
    .in_key         (in_key),
    .in_dec         (in_dec),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_text       (out_text),
    .busy           (busy),
    .core_start     (core_start),
    .core_data_in   (core_data_in),
    .core_key_in    (core_key_in),
    .core_selEncDec (core_selEncDec),
    .core_data_out  (core_data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- AES-128 reference (FIPS-197 arithmetic) ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
      sbox[a]  = s;
      isbox[s] = 8'(a);
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] text, input logic [127:0] key,
                                           input logic dec);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = text[127-8*i -: 8];
    if (!dec) begin
      for (int r = 0; r <= 10; r++) begin
        if (r > 0) begin
          for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
          for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++) t[q+4*c] = s[q+4*((c+q)%4)];
          for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (r < 10) begin
              s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
              s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
              s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
              s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
            end else begin
              s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
            end
          end
        end
        for (int c = 0; c < 4; c++)
          for (int q = 0; q < 4; q++) s[q+4*c] = s[q+4*c] ^ w[4*r+c][31-8*q -: 8];
      end
    end else begin
      for (int r = 10; r >= 0; r--) begin
        if (r < 10) begin
          for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++) t[q+4*((c+q)%4)] = s[q+4*c];
          for (int i = 0; i < 16; i++) s[i] = isbox[t[i]];
        end
        for (int c = 0; c < 4; c++)
          for (int q = 0; q < 4; q++) s[q+4*c] = s[q+4*c] ^ w[4*r+c][31-8*q -: 8];
        if (r > 0 && r < 10) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
            s[4*c+1] = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
            s[4*c+2] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
            s[4*c+3] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
          end
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- word-serial core model ----------------
  // Samples four words on the cycles after core_start falls; presents the four result words so
  // that word 0 sits on data_out 79 cycles after word 3 was on data_in. Garbage otherwise.
  logic [127:0] cm_in, cm_res;
  int           cm_n, cm_cnt;
  bit           cm_arm, cm_run;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cm_arm = 1'b0;
      cm_run = 1'b0;
      cm_n   = 0;
      cm_cnt = 0;
      core_data_out <= $urandom;
    end else begin
      core_data_out <= $urandom;
      if (core_start) begin
        cm_arm = 1'b1;
        cm_run = 1'b0;
        cm_n   = 0;
      end else if (cm_arm && cm_n < 4) begin
        cm_in[127-32*cm_n -: 32] = core_data_in;
        cm_n++;
        if (cm_n == 4) begin
          cm_res = aes_ref(cm_in, core_key_in, core_selEncDec);
          cm_run = 1'b1;
          cm_arm = 1'b0;
          cm_cnt = 0;
        end
      end else if (cm_run) begin
        cm_cnt++;
        if (cm_cnt >= 78 && cm_cnt < 82) core_data_out <= cm_res[127-32*(cm_cnt-78) -: 32];
        if (cm_cnt >= 82) cm_run = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic         ov_prev = 1'b0;
  logic [127:0] mon_exp;

  always @(negedge clk) begin
    if (reset) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) check("latency", 128'(cyc - acc_cyc), 128'(LAT));
      ov_prev = out_valid;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_result", out_text, 128'h0);
        end else begin
          mon_exp = sb_q.pop_front();
          check("result", out_text, mon_exp);
          n_done++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [127:0] txt, input logic [127:0] key, input logic dec,
                      input logic [127:0] exp, output int waited, output int start_lo);
    in_text  = txt;
    in_key   = key;
    in_dec   = dec;
    in_valid = 1'b1;
    waited   = 0;
    start_lo = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (!core_start) start_lo++;
      if (waited > 400) break;
    end
    if (waited > 400) begin
      check("accept_timeout", 128'(in_ready), 128'(1));
    end else begin
      sb_q.push_back(exp);
      acc_cyc = cyc + 1;
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_seen", 128'(out_valid), 128'(1));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", 128'(sb_q.size()), 128'(0));
    @(negedge clk);
    check("idle_busy", 128'(busy), 128'(0));
    check("idle_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 128'(in_ready), 128'(0));
    check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    check({tag, "_out_text"}, out_text, 128'h0);
    check({tag, "_busy"}, 128'(busy), 128'(1));
    check({tag, "_core_start"}, 128'(core_start), 128'(1));
    check({tag, "_core_data_in"}, 128'(core_data_in), 128'(0));
    check({tag, "_core_key_in"}, core_key_in, 128'h0);
    check({tag, "_core_sel"}, 128'(core_selEncDec), 128'(1));
  endtask

  initial begin
    int           w, lo, errs;
    logic [127:0] txt, key, e;
    logic         dec, stall;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_text   = '0;
    in_key    = '0;
    in_dec    = 1'b0;
    out_ready = 1'b1;
    build_sbox();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk);
    #2;
    reset = 1'b0;

    // in_valid offered straight out of reset: nothing accepted during warm-up
    send(CT, KEY, 1'b1, PT, w, lo);
    check("init_wait", 128'(w), 128'(INIT_CYC));
    check("init_core_start_low", 128'(lo), 128'(0));
    wait_drain();

    send(PT, KEY, 1'b0, CT, w, lo);
    wait_drain();

    // back-pressure: result must be held untouched
    txt = {$urandom, $urandom, $urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    e   = aes_ref(txt, key, 1'b0);
    out_ready = 1'b0;
    send(txt, key, 1'b0, e, w, lo);
    wait_valid();
    errs = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!out_valid || in_ready || out_text !== e || core_start) errs++;
    end
    check("backpressure_hold", 128'(errs), 128'(0));
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain();

    // inputs scribbled on while the core is working
    send(CT, KEY, 1'b1, PT, w, lo);
    repeat (30) @(posedge clk);
    #2;
    in_text = {$urandom, $urandom, $urandom, $urandom};
    in_key  = {$urandom, $urandom, $urandom, $urandom};
    in_dec  = 1'b0;
    wait_drain();

    for (int k = 0; k < 6; k++) begin
      txt   = {$urandom, $urandom, $urandom, $urandom};
      key   = {$urandom, $urandom, $urandom, $urandom};
      dec   = 1'($urandom_range(0, 1));
      stall = 1'($urandom_range(0, 1));
      out_ready = ~stall;
      send(txt, key, dec, aes_ref(txt, key, dec), w, lo);
      if (stall) begin
        wait_valid();
        repeat ($urandom_range(1, 20)) @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
      wait_drain();
    end

    // reset during the latency wait discards the block
    txt = {$urandom, $urandom, $urandom, $urandom};
    send(txt, KEY, 1'b0, aes_ref(txt, KEY, 1'b0), w, lo);
    repeat (40) @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    sb_q.delete();
    @(posedge clk);
    #2;
    reset = 1'b0;
    send(CT, KEY, 1'b1, PT, w, lo);
    check("reinit_wait", 128'(w), 128'(INIT_CYC));
    wait_drain();

    check("blocks_retired", 128'(n_done), 128'(11));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
